// File: rtl/if_id_stage_reg_if.sv
// Fetch-to-decode handshake bundle for the IF/ID pipeline register.
// The slave modport is the stage register; the master modport is the fetch/decode environment.
interface if_id_stage_reg_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic [DATA_W-1:0] in_instr;
  logic [DATA_W-1:0] in_pc4;
  logic              in_ready;
  logic              stall;
  logic              flush;
  logic              out_valid;
  logic [DATA_W-1:0] out_instr;
  logic [DATA_W-1:0] out_pc4;
  logic [4:0]        out_rs;
  logic [4:0]        out_rt;

  modport slave (
    input  in_valid, in_instr, in_pc4, stall, flush,
    output in_ready, out_valid, out_instr, out_pc4, out_rs, out_rt
  );

  modport master (
    output in_valid, in_instr, in_pc4, stall, flush,
    input  in_ready, out_valid, out_instr, out_pc4, out_rs, out_rt
  );
endinterface

// File: rtl/if_id_stage_reg.sv
// IF/ID pipeline register with a one-entry skid buffer, flush and stall handling.
// Optional stall-cycle counter enabled by defining IF_ID_STALL_CNT_EN.
module if_id_stage_reg #(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  if_id_stage_reg_if.slave    bus
`ifdef IF_ID_STALL_CNT_EN
  ,
  output logic [15:0]         stall_cycles
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  state_t            state_r, state_n_s;
  logic [DATA_W-1:0] main_instr_r, main_instr_n_s;
  logic [DATA_W-1:0] main_pc4_r, main_pc4_n_s;
  logic [DATA_W-1:0] skid_instr_r, skid_instr_n_s;
  logic [DATA_W-1:0] skid_pc4_r, skid_pc4_n_s;
  logic              in_ready_r, in_ready_n_s;
  logic              out_valid_s;
  logic              accept_s;
  logic              consume_s;

  assign out_valid_s = (state_r != ST_EMPTY);
  assign accept_s    = bus.in_valid && in_ready_r;
  assign consume_s   = out_valid_s && !bus.stall;

  // The main register is zeroed whenever the stage empties, so out_* read it directly as a NOP.
  assign bus.out_valid = out_valid_s;
  assign bus.out_instr = main_instr_r;
  assign bus.out_pc4   = main_pc4_r;
  assign bus.out_rs    = main_instr_r[25:21];
  assign bus.out_rt    = main_instr_r[20:16];
  assign bus.in_ready  = in_ready_r;

  // Next-state and next-register selection.
  always_comb begin
    state_n_s      = state_r;
    main_instr_n_s = main_instr_r;
    main_pc4_n_s   = main_pc4_r;
    skid_instr_n_s = skid_instr_r;
    skid_pc4_n_s   = skid_pc4_r;
    case (state_r)
      ST_EMPTY: begin
        if (accept_s) begin
          state_n_s      = ST_FULL;
          main_instr_n_s = bus.in_instr;
          main_pc4_n_s   = bus.in_pc4;
        end else begin
          state_n_s      = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (consume_s && accept_s) begin
          main_instr_n_s = bus.in_instr;
          main_pc4_n_s   = bus.in_pc4;
        end else if (consume_s) begin
          state_n_s      = ST_EMPTY;
          main_instr_n_s = {DATA_W{1'b0}};
          main_pc4_n_s   = {DATA_W{1'b0}};
        end else if (accept_s) begin
          state_n_s      = ST_SKID;
          skid_instr_n_s = bus.in_instr;
          skid_pc4_n_s   = bus.in_pc4;
        end else begin
          state_n_s      = ST_FULL;
        end
      end
      ST_SKID: begin
        if (consume_s) begin
          state_n_s      = ST_FULL;
          main_instr_n_s = skid_instr_r;
          main_pc4_n_s   = skid_pc4_r;
          skid_instr_n_s = {DATA_W{1'b0}};
          skid_pc4_n_s   = {DATA_W{1'b0}};
        end else begin
          state_n_s      = ST_SKID;
        end
      end
      default: begin
        state_n_s      = ST_EMPTY;
        main_instr_n_s = {DATA_W{1'b0}};
        main_pc4_n_s   = {DATA_W{1'b0}};
        skid_instr_n_s = {DATA_W{1'b0}};
        skid_pc4_n_s   = {DATA_W{1'b0}};
      end
    endcase
    if (bus.flush) begin
      state_n_s      = ST_EMPTY;
      main_instr_n_s = {DATA_W{1'b0}};
      main_pc4_n_s   = {DATA_W{1'b0}};
      skid_instr_n_s = {DATA_W{1'b0}};
      skid_pc4_n_s   = {DATA_W{1'b0}};
    end else begin
      state_n_s      = state_n_s;
    end
    in_ready_n_s = (state_n_s != ST_SKID);
  end

  // State, data and ready registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_EMPTY;
      main_instr_r <= {DATA_W{1'b0}};
      main_pc4_r   <= {DATA_W{1'b0}};
      skid_instr_r <= {DATA_W{1'b0}};
      skid_pc4_r   <= {DATA_W{1'b0}};
      in_ready_r   <= 1'b1;
    end else begin
      state_r      <= state_n_s;
      main_instr_r <= main_instr_n_s;
      main_pc4_r   <= main_pc4_n_s;
      skid_instr_r <= skid_instr_n_s;
      skid_pc4_r   <= skid_pc4_n_s;
      in_ready_r   <= in_ready_n_s;
    end
  end

`ifdef IF_ID_STALL_CNT_EN
  logic [15:0] stall_cnt_r;

  assign stall_cycles = stall_cnt_r;

  // Saturating count of cycles in which decode holds a live beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_r <= 16'h0000;
    end else if (out_valid_s && bus.stall && !bus.flush && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'h0001;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end
`endif

endmodule

// File: tb/tb_if_id_stage_reg.sv
// Self-checking bench for if_id_stage_reg: queue-based reference model plus directed literal checks.
module tb_if_id_stage_reg;
  localparam int DATA_W = 32;

  logic clk;
  logic reset;
  if_id_stage_reg_if #(.DATA_W(DATA_W)) bus();

`ifdef IF_ID_STALL_CNT_EN
  logic [15:0] stall_cycles;
  logic [15:0] cnt_m;
`endif

  if_id_stage_reg #(.DATA_W(DATA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
`ifdef IF_ID_STALL_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: ordered queue of held beats {instr, pc4}, capacity two.
  logic [2*DATA_W-1:0] q_m[$];
  logic                ready_m = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    logic acc, con, ov;
    logic [DATA_W-1:0] ei, ep;
    @(posedge clk);
    ov  = (q_m.size() > 0);
    acc = bus.in_valid && ready_m;
    con = ov && !bus.stall;
`ifdef IF_ID_STALL_CNT_EN
    if (reset) cnt_m = 16'h0000;
    else if (ov && bus.stall && !bus.flush && cnt_m != 16'hFFFF) cnt_m = cnt_m + 16'h0001;
`endif
    if (reset || bus.flush) begin
      q_m.delete();
      ready_m = 1'b1;
    end else begin
      if (con) void'(q_m.pop_front());
      if (acc) q_m.push_back({bus.in_instr, bus.in_pc4});
      ready_m = (q_m.size() < 2);
    end
    #1;
    ei = (q_m.size() > 0) ? q_m[0][2*DATA_W-1:DATA_W] : {DATA_W{1'b0}};
    ep = (q_m.size() > 0) ? q_m[0][DATA_W-1:0]        : {DATA_W{1'b0}};
    chk("out_valid", {63'd0, bus.out_valid}, {63'd0, (q_m.size() > 0)});
    chk("out_instr", {32'd0, bus.out_instr}, {32'd0, ei});
    chk("out_pc4",   {32'd0, bus.out_pc4},   {32'd0, ep});
    chk("in_ready",  {63'd0, bus.in_ready},  {63'd0, ready_m});
    chk("out_rs",    {59'd0, bus.out_rs},    {59'd0, ei[25:21]});
    chk("out_rt",    {59'd0, bus.out_rt},    {59'd0, ei[20:16]});
`ifdef IF_ID_STALL_CNT_EN
    chk("stall_cycles", {48'd0, stall_cycles}, {48'd0, cnt_m});
`endif
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic st, input logic fl);
    bus.in_valid = v;
    bus.in_instr = ins;
    bus.in_pc4   = ins + 32'h0000_1000;
    bus.stall    = st;
    bus.flush    = fl;
  endtask

  initial begin
`ifdef IF_ID_STALL_CNT_EN
    cnt_m = 16'h0000;
`endif
    reset = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    step();
    step();
    chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_out_instr", {32'd0, bus.out_instr}, 64'd0);
    chk("rst_in_ready",  {63'd0, bus.in_ready},  64'd1);
    reset = 1'b0;

    // streaming
    drive(1'b1, 32'h2008_0001, 1'b0, 1'b0); step();
    chk("stream_a", {32'd0, bus.out_instr}, 64'h2008_0001);
    drive(1'b1, 32'h2009_0002, 1'b0, 1'b0); step();
    chk("stream_b", {32'd0, bus.out_instr}, 64'h2009_0002);
    chk("stream_rt", {59'd0, bus.out_rt}, 64'd9);
    drive(1'b1, 32'h200A_0003, 1'b0, 1'b0); step();
    chk("stream_c", {32'd0, bus.out_instr}, 64'h200A_0003);
    chk("stream_rdy", {63'd0, bus.in_ready}, 64'd1);
    drive(1'b0, 32'h0, 1'b0, 1'b0); step();
    chk("stream_drain", {63'd0, bus.out_valid}, 64'd0);

    // skid
    drive(1'b1, 32'h2008_0001, 1'b0, 1'b0); step();
    drive(1'b1, 32'h2009_0002, 1'b1, 1'b0); step();
    chk("skid_hold", {32'd0, bus.out_instr}, 64'h2008_0001);
    chk("skid_rdy0", {63'd0, bus.in_ready}, 64'd0);
    drive(1'b0, 32'h0, 1'b0, 1'b0); step();
    chk("skid_next", {32'd0, bus.out_instr}, 64'h2009_0002);
    chk("skid_rdy1", {63'd0, bus.in_ready}, 64'd1);
    step();

    // flush in SKID, overriding stall
    drive(1'b1, 32'h2008_0001, 1'b0, 1'b0); step();
    drive(1'b1, 32'h2009_0002, 1'b1, 1'b0); step();
    drive(1'b1, 32'h200A_0003, 1'b1, 1'b1); step();
    chk("flush_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("flush_instr", {32'd0, bus.out_instr}, 64'd0);
    chk("flush_rdy",   {63'd0, bus.in_ready},  64'd1);
    drive(1'b0, 32'h0, 1'b0, 1'b0); step(); step();
    chk("flush_gone", {63'd0, bus.out_valid}, 64'd0);

    // reset mid-SKID
    drive(1'b1, 32'h2008_0001, 1'b0, 1'b0); step();
    drive(1'b1, 32'h2009_0002, 1'b1, 1'b0); step();
    reset = 1'b1; drive(1'b1, 32'h200A_0003, 1'b1, 1'b1); step();
    chk("rst_mid_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_mid_pc4",   {32'd0, bus.out_pc4},   64'd0);
    chk("rst_mid_rdy",   {63'd0, bus.in_ready},  64'd1);
    reset = 1'b0;
    drive(1'b1, 32'h8C08_0004, 1'b0, 1'b0); step();
    chk("rst_next_instr", {32'd0, bus.out_instr}, 64'h8C08_0004);
    chk("rst_next_rt",    {59'd0, bus.out_rt},    64'd8);
    drive(1'b0, 32'h0, 1'b0, 1'b0); step();

`ifdef IF_ID_STALL_CNT_EN
    reset = 1'b1; step(); reset = 1'b0;
    drive(1'b1, 32'h2008_0001, 1'b0, 1'b0); step();
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step();
    chk("cnt_five", {48'd0, stall_cycles}, 64'd5);
    drive(1'b0, 32'h0, 1'b0, 1'b0); step();
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step();
    chk("cnt_empty", {48'd0, stall_cycles}, 64'd5);
    drive(1'b1, 32'h2008_0001, 1'b0, 1'b0); step();
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 70000 && cnt_m != 16'hFFFF; i++) step();
    step(); step();
    chk("cnt_sat", {48'd0, stall_cycles}, 64'hFFFF);
    drive(1'b0, 32'h0, 1'b0, 1'b0); step();
`endif

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      drive($urandom_range(0, 3) != 0, $urandom(), $urandom_range(0, 2) == 0,
            $urandom_range(0, 39) == 0);
      step();
    end
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/if_id_stage_reg.md
IF_ID_STAGE_REG -- requirements
Module: if_id_stage_reg

Interface
REQ-001 SHALL have parameter: DATA_W, 32, width of the instruction and PC+4 fields.
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: in_valid  input  1  fetch presents a beat.
REQ-005 SHALL have port: in_instr  input  DATA_W  fetched instruction.
REQ-006 SHALL have port: in_pc4  input  DATA_W  PC+4 of the fetched instruction.
REQ-007 SHALL have port: in_ready  output  1  registered; stage can accept a beat this cycle.
REQ-008 SHALL have port: stall  input  1  hazard hold from decode; output beat not consumed.
REQ-009 SHALL have port: flush  input  1  taken branch/jump; discard all held beats.
REQ-010 SHALL have port: out_valid  output  1  out_instr/out_pc4 hold a live instruction.
REQ-011 SHALL have port: out_instr  output  DATA_W  instruction to decode.
REQ-012 SHALL have port: out_pc4  output  DATA_W  PC+4 to decode.
REQ-013 SHALL have ports: out_rs, out_rt  output  5 each  combinational out_instr[25:21], out_instr[20:16].

Function
REQ-014 SHALL implement states EMPTY (no beat), FULL (main register only), SKID (main + skid register occupied).
REQ-015 SHALL accept a beat when in_valid && in_ready, and consume the output beat when out_valid && !stall.
REQ-016 SHALL transition EMPTY -> FULL on accept; otherwise remain EMPTY.
REQ-017 SHALL, in FULL: consume+accept -> FULL (main reloaded); consume only -> EMPTY; accept only -> SKID (beat into skid); neither -> FULL (hold).
REQ-018 SHALL, in SKID: consume -> FULL (main <= skid); otherwise hold SKID; no accept possible.
REQ-019 SHALL drive in_ready from a register equal to 1 when next state is EMPTY or FULL, 0 when next state is SKID.
REQ-020 SHALL present an accepted beat at out_* on the cycle after acceptance (latency 1) when entering from EMPTY or when consumed same cycle.
REQ-021 SHALL preserve strict program order: skid beat always follows main beat; no beat dropped or duplicated absent flush.
REQ-022 SHALL force out_instr and out_pc4 to 0 (MIPS NOP) whenever out_valid is 0.
REQ-023 SHALL, on flush, go to EMPTY next cycle, discard main, skid and any beat accepted that cycle, and set in_ready to 1; flush overrides stall.
REQ-024 SHALL hold main register contents bit-exact across any number of stall cycles.

Reset
REQ-025 SHALL, on reset, enter EMPTY with out_valid=0, out_instr=0, out_pc4=0, in_ready=1 on the following cycle.
REQ-026 SHALL give reset priority over flush, stall and in_valid, including mid-SKID.

Configuration
REQ-027 SHALL, when macro IF_ID_STALL_CNT_EN is defined, add output stall_cycles (16 bits) counting cycles with out_valid && stall && !flush, saturating at 16'hFFFF, cleared only by reset.
REQ-028 SHALL, when IF_ID_STALL_CNT_EN is undefined, omit stall_cycles port and counter logic entirely; all other behaviour identical.

Verification
REQ-029 SHALL cover streaming: in_valid=1 with instr 0x20080001, 0x20090002, 0x200A0003 on consecutive cycles, stall=0 -> out_instr shows each one cycle later, in_ready stays 1.
REQ-030 SHALL cover skid: out holds 0x20080001, stall=1 while 0x20090002 accepted -> state SKID, in_ready=0 next cycle, out holds 0x20080001; stall=0 -> out 0x20090002 next cycle, in_ready=1.
REQ-031 SHALL cover flush in SKID: flush=1 with stall=1 -> next cycle out_valid=0, out_instr=0, in_ready=1; neither held beat ever appears.
REQ-032 SHALL cover reset mid-operation: reset=1 in SKID -> next cycle out_valid=0, out_pc4=0, in_ready=1; next accepted beat 0x8C080004 appears normally.
REQ-033 SHALL cover counter (IF_ID_STALL_CNT_EN): 5 stall cycles with out_valid=1 -> stall_cycles=5; stall with out_valid=0 -> no increment; preloaded 16'hFFFF stays 16'hFFFF.
